// File: rtl/tcp_rx_flow_setup_arb.sv
// tcp_rx_flow_setup_arb
// Arbitrates slow-path TCP connection-setup requests from NUM_CHAN channels
// and walks one accepted request at a time through flow-ID allocation,
// per-flow state initialisation, SYN-ACK enqueue and application notification.
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   slow_path_val/flags/rdy          per-channel request in, one-hot accept out
//   slow_path_done_val/rdy           completion handshake with done_chan,
//                                    drop_pkt, drop_reason
//   flowid_manager_req/avail/in      pop a flow ID from the free list
//   flowid_release_val/rdy           return cur_flowid after an init timeout
//   cur_flowid                       flow ID of the request in progress
//   init_state_*, send_pkt_enqueue_*, app_flow_notif_*  downstream handshakes
//   drop_cnt_nosyn/noid/tmo          saturating drop counters
module tcp_rx_flow_setup_arb #(
  parameter int NUM_CHAN     = 2,
  parameter int FLOWID_W     = 8,
  parameter int MAX_RETRY    = 4,
  parameter int INIT_TIMEOUT = 64,
  parameter int CNT_W        = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_CHAN-1:0]   slow_path_val,
  input  logic [8*NUM_CHAN-1:0] slow_path_flags,
  output logic [NUM_CHAN-1:0]   slow_path_rdy,
  output logic                  slow_path_done_val,
  input  logic                  slow_path_done_rdy,
  output logic [2:0]            done_chan,
  output logic                  drop_pkt,
  output logic [1:0]            drop_reason,
  output logic                  flowid_manager_req,
  input  logic                  flowid_avail,
  input  logic [FLOWID_W-1:0]   flowid_in,
  output logic                  flowid_release_val,
  input  logic                  flowid_release_rdy,
  output logic [FLOWID_W-1:0]   cur_flowid,
  output logic                  init_state_val,
  input  logic                  init_state_rdy,
  output logic                  send_pkt_enqueue_val,
  input  logic                  send_pkt_enqueue_rdy,
  output logic                  app_flow_notif_val,
  input  logic                  app_flow_notif_rdy,
  output logic [CNT_W-1:0]      drop_cnt_nosyn,
  output logic [CNT_W-1:0]      drop_cnt_noid,
  output logic [CNT_W-1:0]      drop_cnt_tmo
);

  localparam int unsigned NCH = NUM_CHAN;
  localparam int RETRY_W = $clog2(MAX_RETRY + 2);
  localparam int WAIT_W  = (INIT_TIMEOUT > 1) ? $clog2(INIT_TIMEOUT) : 1;
  localparam logic [RETRY_W-1:0] RETRY_LAST = RETRY_W'(MAX_RETRY);
  // The wait counter is 0 on the first INIT_STATE cycle, so the timeout
  // decision is taken on the INIT_TIMEOUT-th cycle spent waiting.
  localparam logic [WAIT_W-1:0]  TMO_LAST =
    WAIT_W'((INIT_TIMEOUT > 0) ? INIT_TIMEOUT - 1 : 0);

  typedef enum logic [2:0] {
    IDLE, NEW_FLOWID, INIT_STATE, SEND_SYN_ACK, NOTIF_APP, RELEASE, FIN
  } state_t;

  typedef enum logic [1:0] {
    R_NONE = 2'b00, R_NOSYN = 2'b01, R_NOID = 2'b10, R_TMO = 2'b11
  } reason_t;

  state_t                state_q, state_d;
  reason_t               reason_q, reason_d;
  logic [2:0]            last_q, last_d;
  logic [2:0]            chan_q, chan_d;
  logic [RETRY_W-1:0]    retry_q, retry_d;
  logic [WAIT_W-1:0]     wait_q, wait_d;
  logic [FLOWID_W-1:0]   flowid_q, flowid_d;
  logic [CNT_W-1:0]      nosyn_q, nosyn_d, noid_q, noid_d, tmo_q, tmo_d;

  logic [2:0]            grant;
  logic                  grant_vld;
  logic [7:0]            sel_flags;

  // Round-robin: first valid channel strictly after last_q, wrapping.
  always_comb begin
    grant     = '0;
    grant_vld = 1'b0;
    for (int unsigned k = 1; k <= NCH; k++) begin
      for (int unsigned i = 0; i < NCH; i++) begin
        if (!grant_vld && slow_path_val[i] && (i == (32'(last_q) + k) % NCH)) begin
          grant     = 3'(i);
          grant_vld = 1'b1;
        end
      end
    end
  end

  always_comb begin
    sel_flags     = '0;
    slow_path_rdy = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (grant == 3'(i)) begin
        sel_flags = slow_path_flags[8*i +: 8];
        slow_path_rdy[i] = (state_q == IDLE) && grant_vld && !rst;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    reason_d = reason_q;
    last_d   = last_q;
    chan_d   = chan_q;
    retry_d  = retry_q;
    wait_d   = wait_q;
    flowid_d = flowid_q;
    nosyn_d  = nosyn_q;
    noid_d   = noid_q;
    tmo_d    = tmo_q;
    slow_path_done_val   = 1'b0;
    drop_pkt             = 1'b0;
    flowid_manager_req   = 1'b0;
    flowid_release_val   = 1'b0;
    init_state_val       = 1'b0;
    send_pkt_enqueue_val = 1'b0;
    app_flow_notif_val   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (grant_vld) begin
          chan_d  = grant;
          retry_d = '0;
          if (sel_flags == 8'h02) begin
            reason_d = R_NONE;
            state_d  = NEW_FLOWID;
          end else begin
            reason_d = R_NOSYN;
            state_d  = FIN;
          end
        end
      end
      NEW_FLOWID: begin
        if (flowid_avail) begin
          flowid_manager_req = 1'b1;
          flowid_d = flowid_in;
          wait_d   = '0;
          state_d  = INIT_STATE;
        end else if (retry_q == RETRY_LAST) begin
          reason_d = R_NOID;
          state_d  = FIN;
        end else begin
          retry_d = retry_q + 1'b1;
        end
      end
      INIT_STATE: begin
        init_state_val = 1'b1;
        if (init_state_rdy) begin
          state_d = SEND_SYN_ACK;
        end else if ((INIT_TIMEOUT > 0) && (wait_q == TMO_LAST)) begin
          reason_d = R_TMO;
          state_d  = RELEASE;
        end else if (wait_q != TMO_LAST) begin
          wait_d = wait_q + 1'b1;
        end
      end
      SEND_SYN_ACK: begin
        send_pkt_enqueue_val = 1'b1;
        if (send_pkt_enqueue_rdy) state_d = NOTIF_APP;
      end
      NOTIF_APP: begin
        app_flow_notif_val = 1'b1;
        if (app_flow_notif_rdy) state_d = FIN;
      end
      RELEASE: begin
        flowid_release_val = 1'b1;
        if (flowid_release_rdy) state_d = FIN;
      end
      FIN: begin
        slow_path_done_val = 1'b1;
        drop_pkt = (reason_q != R_NONE);
        if (slow_path_done_rdy) begin
          state_d = IDLE;
          last_d  = chan_q;
          unique case (reason_q)
            R_NOSYN: if (nosyn_q != '1) nosyn_d = nosyn_q + 1'b1;
            R_NOID:  if (noid_q  != '1) noid_d  = noid_q  + 1'b1;
            R_TMO:   if (tmo_q   != '1) tmo_d   = tmo_q   + 1'b1;
            default: ;
          endcase
        end
      end
      default: state_d = IDLE;
    endcase

    if (rst) begin
      slow_path_done_val   = 1'b0;
      drop_pkt             = 1'b0;
      flowid_manager_req   = 1'b0;
      flowid_release_val   = 1'b0;
      init_state_val       = 1'b0;
      send_pkt_enqueue_val = 1'b0;
      app_flow_notif_val   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      reason_q <= R_NONE;
      last_q   <= 3'(NUM_CHAN - 1);
      chan_q   <= '0;
      retry_q  <= '0;
      wait_q   <= '0;
      flowid_q <= '0;
      nosyn_q  <= '0;
      noid_q   <= '0;
      tmo_q    <= '0;
    end else begin
      state_q  <= state_d;
      reason_q <= reason_d;
      last_q   <= last_d;
      chan_q   <= chan_d;
      retry_q  <= retry_d;
      wait_q   <= wait_d;
      flowid_q <= flowid_d;
      nosyn_q  <= nosyn_d;
      noid_q   <= noid_d;
      tmo_q    <= tmo_d;
    end
  end

  assign done_chan      = chan_q;
  assign drop_reason    = reason_q;
  assign cur_flowid     = flowid_q;
  assign drop_cnt_nosyn = nosyn_q;
  assign drop_cnt_noid  = noid_q;
  assign drop_cnt_tmo   = tmo_q;

endmodule

// File: tb/tb_tcp_rx_flow_setup_arb.sv
// tb_tcp_rx_flow_setup_arb
// Directed bench for tcp_rx_flow_setup_arb: arbitration order, non-SYN drop,
// flow-ID retry exhaustion, init timeout and release, backpressure holding,
// counter saturation (narrow CNT_W so saturation is reachable) and reset
// abandonment of an in-flight request.
module tb_tcp_rx_flow_setup_arb;

  localparam int NUM_CHAN = 2;
  localparam int FLOWID_W = 8;
  localparam int CNT_W    = 2;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NUM_CHAN-1:0]   slow_path_val;
  logic [8*NUM_CHAN-1:0] slow_path_flags;
  logic [NUM_CHAN-1:0]   slow_path_rdy;
  logic                  slow_path_done_val;
  logic                  slow_path_done_rdy;
  logic [2:0]            done_chan;
  logic                  drop_pkt;
  logic [1:0]            drop_reason;
  logic                  flowid_manager_req;
  logic                  flowid_avail;
  logic [FLOWID_W-1:0]   flowid_in;
  logic                  flowid_release_val;
  logic                  flowid_release_rdy;
  logic [FLOWID_W-1:0]   cur_flowid;
  logic                  init_state_val, init_state_rdy;
  logic                  send_pkt_enqueue_val, send_pkt_enqueue_rdy;
  logic                  app_flow_notif_val, app_flow_notif_rdy;
  logic [CNT_W-1:0]      drop_cnt_nosyn, drop_cnt_noid, drop_cnt_tmo;

  int n_chk  = 0;
  int n_pass = 0;

  tcp_rx_flow_setup_arb #(
    .NUM_CHAN(NUM_CHAN), .FLOWID_W(FLOWID_W), .MAX_RETRY(4),
    .INIT_TIMEOUT(8), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .slow_path_val(slow_path_val), .slow_path_flags(slow_path_flags),
    .slow_path_rdy(slow_path_rdy),
    .slow_path_done_val(slow_path_done_val), .slow_path_done_rdy(slow_path_done_rdy),
    .done_chan(done_chan), .drop_pkt(drop_pkt), .drop_reason(drop_reason),
    .flowid_manager_req(flowid_manager_req), .flowid_avail(flowid_avail),
    .flowid_in(flowid_in),
    .flowid_release_val(flowid_release_val), .flowid_release_rdy(flowid_release_rdy),
    .cur_flowid(cur_flowid),
    .init_state_val(init_state_val), .init_state_rdy(init_state_rdy),
    .send_pkt_enqueue_val(send_pkt_enqueue_val), .send_pkt_enqueue_rdy(send_pkt_enqueue_rdy),
    .app_flow_notif_val(app_flow_notif_val), .app_flow_notif_rdy(app_flow_notif_rdy),
    .drop_cnt_nosyn(drop_cnt_nosyn), .drop_cnt_noid(drop_cnt_noid),
    .drop_cnt_tmo(drop_cnt_tmo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Steps until done_val; side collects any downstream activity seen on the way.
  task automatic wait_done(output int cyc, output logic side);
    cyc  = 0;
    side = 1'b0;
    while (!slow_path_done_val && cyc < 40) begin
      side |= flowid_manager_req | init_state_val | send_pkt_enqueue_val |
              app_flow_notif_val | flowid_release_val;
      step();
      cyc++;
    end
    if (!slow_path_done_val) check("done_timeout", 0, 1);
  endtask

  task automatic do_req(input string tag, input logic [1:0] vals, input logic [15:0] flags,
                        input logic [1:0] exp_rdy, input int exp_chan,
                        input logic [1:0] exp_reason, input logic exp_side, input int exp_cyc);
    int   cyc;
    logic side;
    slow_path_val   = vals;
    slow_path_flags = flags;
    #1;
    check({tag, "_rdy"}, slow_path_rdy, exp_rdy);
    step();
    slow_path_val = '0;
    wait_done(cyc, side);
    check({tag, "_cyc"},    cyc, exp_cyc);
    check({tag, "_chan"},   done_chan, exp_chan);
    check({tag, "_reason"}, drop_reason, exp_reason);
    check({tag, "_drop"},   drop_pkt, (exp_reason != 2'b00));
    check({tag, "_side"},   side, exp_side);
    step();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int   cyc;
    logic side;
    logic ok;

    rst = 1'b1;
    slow_path_val = 2'b11;
    slow_path_flags = 16'h0202;
    slow_path_done_rdy = 1'b1;
    flowid_avail = 1'b1;
    flowid_in = 8'h10;
    flowid_release_rdy = 1'b1;
    init_state_rdy = 1'b1;
    send_pkt_enqueue_rdy = 1'b1;
    app_flow_notif_rdy = 1'b1;
    repeat (3) step();
    check("rst_rdy", slow_path_rdy, 0);
    check("rst_vals", {slow_path_done_val, flowid_manager_req, flowid_release_val,
                       init_state_val, send_pkt_enqueue_val, app_flow_notif_val}, 0);
    check("rst_regs", {cur_flowid, done_chan, drop_reason}, 0);
    check("rst_cnts", {drop_cnt_nosyn, drop_cnt_noid, drop_cnt_tmo}, 0);
    rst = 1'b0;
    slow_path_val = '0;
    step();

    // Round-robin with both channels requesting: ch0, ch1, ch0.
    do_req("arb0", 2'b11, 16'h0202, 2'b01, 0, 2'b00, 1'b1, 4);
    check("arb0_fid", cur_flowid, 8'h10);
    do_req("arb1", 2'b11, 16'h0202, 2'b10, 1, 2'b00, 1'b1, 4);
    do_req("arb2", 2'b11, 16'h0202, 2'b01, 0, 2'b00, 1'b1, 4);

    // SYN|ACK on ch1 goes straight to FIN with no downstream activity.
    do_req("nosyn", 2'b10, 16'h1200, 2'b10, 1, 2'b01, 1'b0, 0);
    check("nosyn_cnt", drop_cnt_nosyn, 1);

    // Five misses exhaust the retries; cur_flowid keeps the old capture.
    flowid_avail = 1'b0;
    flowid_in = 8'h55;
    do_req("noid", 2'b01, 16'h0002, 2'b01, 0, 2'b10, 1'b0, 5);
    check("noid_fid", cur_flowid, 8'h10);
    check("noid_cnt", drop_cnt_noid, 1);

    // avail rises on the fifth poll: success.
    flowid_in = 8'hA7;
    slow_path_val = 2'b01;
    slow_path_flags = 16'h0002;
    #1;
    check("retry_rdy", slow_path_rdy, 2'b01);
    step();
    slow_path_val = '0;
    repeat (4) step();
    check("retry_miss4", {slow_path_done_val, flowid_manager_req}, 0);
    flowid_avail = 1'b1;
    #1;
    check("retry_req", flowid_manager_req, 1);
    step();
    check("retry_fid", cur_flowid, 8'hA7);
    check("retry_init", init_state_val, 1);
    wait_done(cyc, side);
    check("retry_reason", {drop_pkt, drop_reason}, 0);
    step();

    // Init timeout after 8 cycles, release stalled 3 cycles.
    init_state_rdy = 1'b0;
    flowid_release_rdy = 1'b0;
    flowid_in = 8'h3C;
    slow_path_val = 2'b01;
    #1;
    step();
    slow_path_val = '0;
    step();
    repeat (7) step();
    check("tmo_c8_init", init_state_val, 1);
    step();
    check("tmo_rel", {flowid_release_val, init_state_val}, 2'b10);
    ok = 1'b1;
    repeat (3) begin
      step();
      ok &= flowid_release_val && (cur_flowid == 8'h3C) && !slow_path_done_val;
    end
    check("tmo_rel_hold", ok, 1);
    flowid_release_rdy = 1'b1;
    step();
    check("tmo_fin", {slow_path_done_val, drop_pkt, drop_reason}, 4'b1111);
    step();
    check("tmo_cnt", drop_cnt_tmo, 1);

    // init_state_rdy on the eighth cycle wins over the timeout.
    slow_path_val = 2'b01;
    #1;
    step();
    slow_path_val = '0;
    step();
    repeat (7) step();
    init_state_rdy = 1'b1;
    #1;
    step();
    check("tmo_rdy8_enq", {send_pkt_enqueue_val, flowid_release_val}, 2'b10);
    wait_done(cyc, side);
    check("tmo_rdy8_reason", {drop_pkt, drop_reason}, 0);
    step();

    // Backpressure on enqueue, notif and done.
    send_pkt_enqueue_rdy = 1'b0;
    app_flow_notif_rdy = 1'b0;
    slow_path_done_rdy = 1'b0;
    flowid_in = 8'h5A;
    slow_path_val = 2'b01;
    #1;
    step();
    slow_path_val = '0;
    step();
    step();
    ok = 1'b1;
    repeat (10) begin
      ok &= send_pkt_enqueue_val && !app_flow_notif_val && (cur_flowid == 8'h5A);
      step();
    end
    check("bp_enq_hold", ok, 1);
    send_pkt_enqueue_rdy = 1'b1;
    step();
    send_pkt_enqueue_rdy = 1'b0;
    ok = 1'b1;
    repeat (10) begin
      ok &= app_flow_notif_val && !send_pkt_enqueue_val && (cur_flowid == 8'h5A);
      step();
    end
    check("bp_notif_hold", ok, 1);
    app_flow_notif_rdy = 1'b1;
    step();
    app_flow_notif_rdy = 1'b0;
    ok = 1'b1;
    repeat (10) begin
      ok &= slow_path_done_val && (done_chan == 3'd0) && (drop_reason == 2'b00) && !drop_pkt;
      step();
    end
    check("bp_done_hold", ok, 1);
    slow_path_done_rdy = 1'b1;
    step();
    check("bp_idle", slow_path_done_val, 0);
    send_pkt_enqueue_rdy = 1'b1;
    app_flow_notif_rdy = 1'b1;

    // nosyn counter: 1 -> 2 -> 3 -> stays 3.
    for (int i = 0; i < 3; i++)
      do_req("sat", 2'b01, 16'h0010, 2'b01, 0, 2'b01, 1'b0, 0);
    check("nosyn_sat", drop_cnt_nosyn, 2'b11);

    // Reset while stuck in SEND_SYN_ACK on ch1; last grant was ch0.
    send_pkt_enqueue_rdy = 1'b0;
    slow_path_val = 2'b10;
    slow_path_flags = 16'h0200;
    #1;
    check("rst_req_rdy", slow_path_rdy, 2'b10);
    step();
    slow_path_val = '0;
    step();
    step();
    check("rst_pre_enq", send_pkt_enqueue_val, 1);
    rst = 1'b1;
    step();
    check("rst_vals_drop", {slow_path_done_val, flowid_manager_req, flowid_release_val,
                            init_state_val, send_pkt_enqueue_val, app_flow_notif_val,
                            slow_path_rdy}, 0);
    step();
    rst = 1'b0;
    slow_path_val = 2'b11;
    slow_path_flags = 16'h0202;
    #1;
    check("rst_arb_ch0", slow_path_rdy, 2'b01);
    check("rst_no_release", flowid_release_val, 0);
    check("rst_clr", {cur_flowid, drop_cnt_nosyn}, 0);
    slow_path_val = '0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
